// File: rtl/frame_ram_pkg.sv
// frame_ram_pkg: shared types and helpers for the frame RAM.
// Holds the clear-engine state encoding and the per-channel merge used
// by both the write path and the read-during-write bypass.
package frame_ram_pkg;

    localparam int DATA_W_DEF   = 24;
    localparam int CHANNELS_DEF = 3;

    // Widest word / most channels the merge helper can handle.
    localparam int MERGE_MAX_W  = 256;
    localparam int MERGE_MAX_CH = 32;

    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    // Take channel c from new_word when mask[c] is set, otherwise keep
    // old_word. Channel c occupies bits [c*cw +: cw].
    function automatic logic [MERGE_MAX_W-1:0] chan_merge(
        input logic [MERGE_MAX_W-1:0]  old_word,
        input logic [MERGE_MAX_W-1:0]  new_word,
        input logic [MERGE_MAX_CH-1:0] mask,
        input int                      cw
    );
        logic [MERGE_MAX_W-1:0] res;
        int                     ch;
        res = old_word;
        for (int b = 0; b < MERGE_MAX_W; b++) begin
            ch = b / cw;
            if (ch < MERGE_MAX_CH) begin
                if (mask[ch[4:0]]) begin
                    res[b] = new_word[b];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/frame_ram_mc_if.sv
// frame_ram_mc_if: write port, read port and clear control of the frame RAM.
// master = rasteriser / scan-out side, slave = the RAM.
interface frame_ram_mc_if #(
    parameter int DATA_W   = frame_ram_pkg::DATA_W_DEF,
    parameter int CHANNELS = frame_ram_pkg::CHANNELS_DEF,
    parameter int ADDR_W   = 7
);
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [CHANNELS-1:0] wr_mask;
    logic                wr_ready;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                clear_req;
    logic                clear_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, clear_req,
        input  wr_ready, rd_data, rd_valid, clear_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, clear_req,
        output wr_ready, rd_data, rd_valid, clear_busy
    );
endinterface

// File: rtl/frame_ram_clear_seq.sv
// frame_ram_clear_seq: memory clear sweep.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   CLR_RUN  | sweeping: CLEAR_VAL written to address r_cnt each cycle
//   CLR_IDLE | memory available to the normal write port
//
// Reset parks the engine in CLR_RUN at address 0, so a sweep starts on the
// first cycle after release. o_clr_we steers the RAM write port to the sweep.
module frame_ram_clear_seq
    import frame_ram_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear_req,
    output logic              o_clear_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [0:0]        ST_IDLE = CLR_IDLE;
    localparam logic [0:0]        ST_RUN  = CLR_RUN;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              w_running;

    assign w_running = (r_state == ST_RUN);

    // Clear FSM and sweep address counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_cnt == LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_clear_req) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Busy covers the reset itself; the sweep never writes while in reset.
    assign o_clear_busy = i_rst | w_running;
    assign o_clr_we     = w_running & ~i_rst;
    assign o_clr_addr   = r_cnt;

endmodule

// File: rtl/frame_ram_mc.sv
// frame_ram_mc: pixel RAM between rasteriser writes and scan-out reads.
// Per-channel write mask, selectable read-during-write policy, read-valid
// handshake and an automatic clear sweep after reset / on clear_req.
// Build option FRAME_RAM_OUTREG_EN adds an output register (read latency 2).
module frame_ram_mc
    import frame_ram_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                CHANNELS  = CHANNELS_DEF,
    parameter int                ADDR_W    = 7,
    parameter int                DEPTH     = 128,
    parameter int                RDW_MODE  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    frame_ram_mc_if.slave io_bus
);

    localparam int                CW      = DATA_W / CHANNELS;
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

    if ((DATA_W % CHANNELS) != 0 || DEPTH < 1 || DEPTH > (1 << ADDR_W) ||
        DATA_W > MERGE_MAX_W || CHANNELS > MERGE_MAX_CH) begin : g_bad_params
        $error("frame_ram_mc: illegal DATA_W/CHANNELS/DEPTH/ADDR_W combination");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_clear_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_wr_fire;
    logic              w_rdw_hit;
    logic [DATA_W-1:0] w_wr_old;
    logic [DATA_W-1:0] w_wr_merged;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rdw_merged;
    logic [DATA_W-1:0] w_rd_next;

    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    frame_ram_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear_req  (io_bus.clear_req),
        .o_clear_busy (w_clear_busy),
        .o_clr_we     (w_clr_we),
        .o_clr_addr   (w_clr_addr)
    );

    assign w_wr_in_range = ({1'b0, io_bus.wr_addr} < DEPTH_W);
    assign w_rd_in_range = ({1'b0, io_bus.rd_addr} < DEPTH_W);
    // Out-of-range addresses never touch the array; park the index at 0.
    assign w_wr_idx      = w_wr_in_range ? io_bus.wr_addr : '0;
    assign w_rd_idx      = w_rd_in_range ? io_bus.rd_addr : '0;

    assign w_wr_fire = io_bus.wr_en & ~w_clear_busy & w_wr_in_range &
                       (|io_bus.wr_mask);
    assign w_rdw_hit = w_wr_fire & (io_bus.rd_addr == io_bus.wr_addr);

    assign w_wr_old  = r_mem[w_wr_idx];
    assign w_rd_word = r_mem[w_rd_idx];

    assign w_wr_merged  = DATA_W'(chan_merge(MERGE_MAX_W'(w_wr_old),
                                             MERGE_MAX_W'(io_bus.wr_data),
                                             MERGE_MAX_CH'(io_bus.wr_mask), CW));
    assign w_rdw_merged = DATA_W'(chan_merge(MERGE_MAX_W'(w_rd_word),
                                             MERGE_MAX_W'(io_bus.wr_data),
                                             MERGE_MAX_CH'(io_bus.wr_mask), CW));

    // Memory write port: the clear sweep has priority over normal writes.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= CLEAR_VAL;
        end else if (w_wr_fire) begin
            r_mem[w_wr_idx] <= w_wr_merged;
        end
    end

    // Read data selection: clear value while busy or out of range, else the
    // array word, optionally bypassed with the same-cycle merged write.
    always_comb begin
        w_rd_next = w_rd_word;
        if (w_clear_busy || !w_rd_in_range) begin
            w_rd_next = CLEAR_VAL;
        end else if (RDW_MODE == 1 && w_rdw_hit) begin
            w_rd_next = w_rdw_merged;
        end
    end

    // First read stage: capture the word and flag it valid for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= io_bus.rd_en;
            if (io_bus.rd_en) begin
                r_rd_data <= w_rd_next;
            end
        end
    end

`ifdef FRAME_RAM_OUTREG_EN
    logic [DATA_W-1:0] r_rd_data_q;
    logic              r_rd_valid_q;

    // Output register stage: data and valid move together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data_q  <= '0;
            r_rd_valid_q <= 1'b0;
        end else begin
            r_rd_valid_q <= r_rd_valid;
            if (r_rd_valid) begin
                r_rd_data_q <= r_rd_data;
            end
        end
    end

    assign io_bus.rd_data  = r_rd_data_q;
    assign io_bus.rd_valid = r_rd_valid_q;
`else
    assign io_bus.rd_data  = r_rd_data;
    assign io_bus.rd_valid = r_rd_valid;
`endif

    assign io_bus.wr_ready   = ~w_clear_busy;
    assign io_bus.clear_busy = w_clear_busy;

endmodule

// File: tb/tb_frame_ram_mc.sv
// tb_frame_ram_mc: two RAMs (RDW_MODE 0 and 1) driven with identical
// stimulus; read expectations go into a scoreboard queue and a separate
// monitor compares them when rd_valid appears.
`timescale 1ns/1ps
module tb_frame_ram_mc;

    localparam int DW    = 24;
    localparam int CH    = 3;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam logic [DW-1:0] CLR = 24'h000000;
`ifdef FRAME_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [CH-1:0] wr_mask;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          clear_req;

    frame_ram_mc_if #(.DATA_W(DW), .CHANNELS(CH), .ADDR_W(AW)) bus0 ();
    frame_ram_mc_if #(.DATA_W(DW), .CHANNELS(CH), .ADDR_W(AW)) bus1 ();

    assign bus0.wr_en = wr_en;     assign bus1.wr_en = wr_en;
    assign bus0.wr_addr = wr_addr; assign bus1.wr_addr = wr_addr;
    assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;
    assign bus0.wr_mask = wr_mask; assign bus1.wr_mask = wr_mask;
    assign bus0.rd_en = rd_en;     assign bus1.rd_en = rd_en;
    assign bus0.rd_addr = rd_addr; assign bus1.rd_addr = rd_addr;
    assign bus0.clear_req = clear_req; assign bus1.clear_req = clear_req;

    frame_ram_mc #(.DATA_W(DW), .CHANNELS(CH), .ADDR_W(AW), .DEPTH(DEPTH),
                   .RDW_MODE(0), .CLEAR_VAL(CLR))
        u_dut0 (.i_clk(clk), .i_rst(rst), .io_bus(bus0));
    frame_ram_mc #(.DATA_W(DW), .CHANNELS(CH), .ADDR_W(AW), .DEPTH(DEPTH),
                   .RDW_MODE(1), .CLEAR_VAL(CLR))
        u_dut1 (.i_clk(clk), .i_rst(rst), .io_bus(bus1));

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented read result is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (bus0.rd_valid === 1'b1 || bus1.rd_valid === 1'b1) begin
            check("rd_valid_pair", 32'(bus1.rd_valid), 32'(bus0.rd_valid));
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got rd_valid=1 expected no read pending (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("rd_latency", 32'(cyc), 32'(e.cyc));
                check("rd_data_mode0", 32'(bus0.rd_data), 32'(e.d0));
                check("rd_data_mode1", 32'(bus1.rd_data), 32'(e.d1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    endtask

    task automatic push_read(input logic [AW-1:0] a, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        rd_en   = 1'b1;
        rd_addr = a;
        sb.push_back('{d0: e0, d1: e1, cyc: cyc + LAT});
    endtask

    task automatic set_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CH-1:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CH-1:0] m);
        set_write(a, d, m);
        step();
        idle_inputs();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        push_read(a, e, e);
        step();
        idle_inputs();
    endtask

    task automatic drain();
        repeat (LAT + 2) step();
    endtask

    // Back-to-back reads of the whole array, all expected equal to e.
    task automatic read_all(input logic [DW-1:0] e);
        for (int i = 0; i < DEPTH; i++) begin
            push_read(AW'(i), e, e);
            step();
        end
        idle_inputs();
        drain();
    endtask

    task automatic fill(input logic [DW-1:0] offs);
        for (int i = 0; i < DEPTH; i++) begin
            set_write(AW'(i), DW'(i) + offs, 3'b111);
            step();
        end
        idle_inputs();
    endtask

    task automatic count_busy(input string name, input int exp);
        int n = 0;
        while (bus0.clear_busy === 1'b1 && n < 1000) begin
            n++;
            step();
        end
        check(name, 32'(n), 32'(exp));
        check({name, "_ready"}, 32'(bus0.wr_ready), 32'd1);
        check({name, "_pair"}, 32'(bus1.clear_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected run to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        wr_addr = '0; wr_data = '0; wr_mask = '0; rd_addr = '0;
        idle_inputs();
        repeat (3) step();

        check("rst_busy",     32'(bus0.clear_busy), 32'd1);
        check("rst_wr_ready", 32'(bus0.wr_ready),   32'd0);
        check("rst_rd_valid", 32'(bus0.rd_valid),   32'd0);
        check("rst_rd_data",  32'(bus0.rd_data),    32'd0);

        rst = 1'b0;
        count_busy("busy_after_rst", DEPTH);
        read_all(CLR);

        do_write(7'd5, 24'hFFFFFF, 3'b111);
        do_write(7'd5, 24'h123456, 3'b010);
        do_read(7'd5, 24'hFF34FF);
        do_write(7'd5, 24'h000000, 3'b000);
        do_read(7'd5, 24'hFF34FF);
        do_write(7'd127, 24'hABCDEF, 3'b111);
        do_read(7'd127, 24'hABCDEF);

        do_write(7'd9, 24'hAAAAAA, 3'b111);
        set_write(7'd9, 24'h555555, 3'b111);
        push_read(7'd9, 24'hAAAAAA, 24'h555555);
        step();
        set_write(7'd9, 24'h112233, 3'b001);
        push_read(7'd9, 24'h555555, 24'h555533);
        step();
        set_write(7'd10, 24'h777777, 3'b111);
        push_read(7'd9, 24'h555533, 24'h555533);
        step();
        idle_inputs();
        do_read(7'd10, 24'h777777);
        drain();

        fill(24'h000000);
        do_read(7'd77, 24'h00004D);
        do_read(7'd127, 24'h00007F);
        drain();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n = 0;
        while (bus0.clear_busy === 1'b1 && n < 1000) begin
            if (n == 5) begin
                check("wr_ready_busy", 32'(bus0.wr_ready), 32'd0);
                set_write(7'd3, 24'h00DEAD, 3'b111);
            end
            if (n == 10) clear_req = 1'b1;
            if (n == 20) push_read(7'd50, CLR, CLR);
            n++;
            step();
            idle_inputs();
        end
        check("busy_clear_req", 32'(n), 32'(DEPTH));
        read_all(CLR);

        fill(24'h010000);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (60) step();
        rst = 1'b1;
        step();
        step();
        check("midrst_busy",     32'(bus0.clear_busy), 32'd1);
        check("midrst_wr_ready", 32'(bus0.wr_ready),   32'd0);
        check("midrst_rd_valid", 32'(bus0.rd_valid),   32'd0);
        rst = 1'b0;
        count_busy("busy_after_midrst", DEPTH);
        read_all(CLR);

        repeat (4) step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
